// File: rtl/button_pkg.sv
// Shared button indices and status-word layout for the button conditioner
// and the memory-map decode that reads its status word.
package button_pkg;

    localparam int NUM_BUTTONS = 3;

    localparam int BTN_LEFT  = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_START = 2;

    localparam int STAT_EVT_LSB = 0;
    localparam int STAT_LVL_LSB = 3;

    typedef logic [NUM_BUTTONS-1:0] btn_vec_t;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, debounce counter and press edge.
// Optional auto-repeat when BUTTON_AUTO_REPEAT_EN is defined.
module debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_BITS        = 19
`ifdef BUTTON_AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_CYCLES   = 5000000
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic pressed_i,
    output logic level_o,
    output logic pulse_o
);

    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic                stable_q, stable_d;
    logic                prev_q, prev_d;
    logic                pulse_q, pulse_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                rep_fire;

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int REP_MAX  = (REPEAT_DELAY > REPEAT_CYCLES) ? REPEAT_DELAY : REPEAT_CYCLES;
    localparam int REP_BITS = $clog2(REP_MAX + 1);

    logic [REP_BITS-1:0] rep_cnt_q, rep_cnt_d;
    logic                rep_arm_q, rep_arm_d;

    // rep_arm_q marks that the first (long) delay has already elapsed
    always_comb begin
        rep_fire  = 1'b0;
        rep_cnt_d = '0;
        rep_arm_d = 1'b0;
        if (stable_q) begin
            rep_cnt_d = rep_cnt_q + 1'b1;
            rep_arm_d = rep_arm_q;
            if ((!rep_arm_q && rep_cnt_q == REP_BITS'(REPEAT_DELAY)) ||
                ( rep_arm_q && rep_cnt_q == REP_BITS'(REPEAT_CYCLES))) begin
                rep_fire  = 1'b1;
                rep_cnt_d = REP_BITS'(1);
                rep_arm_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_cnt_q <= '0;
            rep_arm_q <= 1'b0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            rep_arm_q <= rep_arm_d;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_comb begin
        sync1_d  = pressed_i;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        prev_d   = stable_q;
        pulse_d  = (stable_q & ~prev_q) | rep_fire;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
            pulse_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            prev_q   <= prev_d;
            pulse_q  <= pulse_d;
            cnt_q    <= cnt_d;
        end
    end

    assign level_o = stable_q;
    assign pulse_o = pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions left/right/start buttons into levels, press pulses and a
// CPU-cleared sticky status word. Auto-repeat: define BUTTON_AUTO_REPEAT_EN.
module button_conditioner
    import button_pkg::*;
#(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_BITS        = 19,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             left_raw,
    input  logic             right_raw,
    input  logic             start_raw,
    input  logic             clear_events,
    output logic             left,
    output logic             right,
    output logic             start,
    output logic [2:0]       press_pulse,
    output logic [WIDTH-1:0] status
);

    if (WIDTH < STAT_LVL_LSB + NUM_BUTTONS) begin : g_bad_width
        $error("button_conditioner: WIDTH too small");
    end
    if (DEBOUNCE_CYCLES < 2 || (64'(1) << CNT_BITS) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_deb
        $error("button_conditioner: bad DEBOUNCE_CYCLES/CNT_BITS");
    end
    if (REPEAT_DELAY < 1 || REPEAT_CYCLES < 1) begin : g_bad_rep
        $error("button_conditioner: bad repeat timing");
    end

    btn_vec_t         raw_vec;
    btn_vec_t         pressed;
    btn_vec_t         level;
    btn_vec_t         pulse;
    logic [WIDTH-1:0] status_q, status_d;

    always_comb begin
        raw_vec            = '0;
        raw_vec[BTN_LEFT]  = left_raw;
        raw_vec[BTN_RIGHT] = right_raw;
        raw_vec[BTN_START] = start_raw;
    end

    assign pressed = ACTIVE_LOW ? ~raw_vec : raw_vec;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_BITS       (CNT_BITS)
`ifdef BUTTON_AUTO_REPEAT_EN
            ,
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_CYCLES  (REPEAT_CYCLES)
`endif
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .pressed_i(pressed[i]),
            .level_o  (level[i]),
            .pulse_o  (pulse[i])
        );
    end

    // a press arriving with the clear still lands, so no event is lost
    always_comb begin
        status_d = '0;
        status_d[STAT_EVT_LSB +: NUM_BUTTONS] =
            (status_q[STAT_EVT_LSB +: NUM_BUTTONS] & ~{NUM_BUTTONS{clear_events}}) | pulse;
        status_d[STAT_LVL_LSB +: NUM_BUTTONS] = level;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            status_q <= '0;
        end else begin
            status_q <= status_d;
        end
    end

    assign left        = level[BTN_LEFT];
    assign right       = level[BTN_RIGHT];
    assign start       = level[BTN_START];
    assign press_pulse = pulse;
    assign status      = status_q;

endmodule
